// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- request/response sequencer wrapped around a non-pipelined ALU.
//
// Accepts one operation at a time, holds it on the ALU inputs with enable
// asserted for LAT cycles, captures the ALU output and presents it downstream.
// Opcodes >= 16 are rejected without touching the ALU and return an error
// result with zero data.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        request handshake
//   in_opcode/in_a/in_b/in_tag  request payload
//   alu_opcode/alu_a/alu_b   operands driven into the ALU (held when idle)
//   alu_enable               ALU enable, high only while executing
//   alu_out                  ALU result
//   res_valid/res_ready      result handshake
//   res_data/res_tag/res_err result payload (err => illegal opcode, data = 0)
//   busy                     high whenever not idle
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5,
  parameter int TAGW  = 4,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAGW-1:0]  in_tag,
  output logic [OPW-1:0]   alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_enable,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [TAGW-1:0]  res_tag,
  output logic             res_err,
  output logic             busy
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [OPW-1:0]   op_q,    op_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [TAGW-1:0]  tag_q,   tag_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             err_q,   err_d;

  logic accept;
  logic legal_op;

  // A new request can be taken when idle, or in RESP on the very edge the
  // current result retires. Reset blocks acceptance combinationally.
  assign in_ready = !rst && ((state_q == IDLE) || ((state_q == RESP) && res_ready));
  assign accept   = in_valid && in_ready;
  assign legal_op = 32'(in_opcode) < 32'd16;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;

    case (state_q)
      EXEC: begin
        if (cnt_q == '0) begin
          data_d  = alu_out;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (res_ready) state_d = IDLE;
      end
      default: ;
    endcase

    // Acceptance overrides the RESP->IDLE retire so back-to-back requests
    // issue on the same edge the previous result leaves.
    if (accept) begin
      op_d  = in_opcode;
      a_d   = in_a;
      b_d   = in_b;
      tag_d = in_tag;
      if (legal_op) begin
        state_d = EXEC;
        cnt_d   = CW'(LAT - 1);
      end else begin
        state_d = RESP;
        data_d  = '0;
        err_d   = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // ALU inputs stay on the last operands outside EXEC to avoid toggling.
  assign alu_opcode = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_enable = (state_q == EXEC);

  assign res_valid  = (state_q == RESP);
  assign res_data   = data_q;
  assign res_tag    = tag_q;
  assign res_err    = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- directed bench for alu_seq with a behavioural ALU (LAT = 2).
// Inputs are driven 1 time unit after each rising edge; outputs are checked
// at that same point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  localparam int WIDTH = 32;
  localparam int OPW   = 5;
  localparam int TAGW  = 4;
  localparam int LAT   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   in_opcode;
  logic [WIDTH-1:0] in_a, in_b;
  logic [TAGW-1:0]  in_tag;
  logic [OPW-1:0]   alu_opcode;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic             alu_enable;
  logic [WIDTH-1:0] alu_out;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [TAGW-1:0]  res_tag;
  logic             res_err;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(WIDTH), .OPW(OPW), .TAGW(TAGW), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_enable (alu_enable),
    .alu_out    (alu_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_tag    (res_tag),
    .res_err    (res_err),
    .busy       (busy)
  );

  // Behavioural ALU: output is only meaningful in the LAT-th enabled cycle;
  // any other time it shows a poison value so early/late sampling is caught.
  int en_cnt = 0;
  always @(posedge clk) en_cnt <= alu_enable ? en_cnt + 1 : 0;

  always_comb begin
    alu_out = 32'hDEAD_BEEF;
    if (alu_enable && en_cnt == LAT - 1) begin
      case (alu_opcode)
        5'd0:    alu_out = alu_a + alu_b;
        5'd8:    alu_out = alu_a & alu_b;
        5'd9:    alu_out = alu_a | alu_b;
        5'd10:   alu_out = alu_a ^ alu_b;
        5'd12:   alu_out = ~(alu_a | alu_b);
        default: alu_out = '0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_req(input logic [OPW-1:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [TAGW-1:0] tag);
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
  endtask

  int t_first;
  int waited;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0;
    in_tag = '0; res_ready = 1'b1;

    // ---------------- reset ----------------
    #1;
    check("rst_in_ready_low", in_ready, 0);
    tick();
    tick();
    check("rst_outputs_zero",
          {alu_opcode, alu_a, alu_b, alu_enable, res_valid, res_err, busy, res_tag} , 0);
    check("rst_res_data", res_data, 0);
    rst = 1'b0;
    #0;
    check("rst_release_in_ready", in_ready, 1);

    // ---------------- AND, tag 3 ----------------
    drive_req(5'd8, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd3);
    check("and_c0_enable", alu_enable, 0);
    tick();                                   // cycle 1
    in_valid = 1'b0;
    check("and_c1_enable", alu_enable, 1);
    check("and_c1_alu_a", alu_a, 32'hF0F0_F0F0);
    check("and_c1_in_ready", in_ready, 0);
    check("and_c1_busy", busy, 1);
    tick();                                   // cycle 2
    check("and_c2_enable", alu_enable, 1);
    check("and_c2_res_valid", res_valid, 0);
    tick();                                   // cycle 3
    check("and_c3_enable", alu_enable, 0);
    check("and_c3_res_valid", res_valid, 1);
    check("and_c3_res_data", res_data, 32'hF000_F000);
    check("and_c3_res_tag", res_tag, 3);
    check("and_c3_res_err", res_err, 0);
    tick();
    check("and_retired", res_valid, 0);
    check("and_idle", busy, 0);

    // ---------------- OR with backpressure ----------------
    res_ready = 1'b0;
    drive_req(5'd9, 32'h0000_000F, 32'h0000_00F0, 4'd4);
    tick(); in_valid = 1'b0;
    tick();
    tick();                                   // cycle 3: RESP
    for (int i = 0; i < 5; i++) begin
      check("bp_res_valid", res_valid, 1);
      check("bp_res_data", res_data, 32'h0000_00FF);
      check("bp_in_ready", in_ready, 0);
      check("bp_alu_enable", alu_enable, 0);
      tick();
    end
    res_ready = 1'b1;
    #0;
    check("bp_release_valid", res_valid, 1);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_tag", res_tag, 4);
    tick();
    check("bp_retired", res_valid, 0);

    // ---------------- back-to-back XOR then NOR ----------------
    drive_req(5'd10, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'd1);
    tick();                                   // cycle 1 of XOR
    drive_req(5'd12, 32'h1234_5678, 32'h0000_FFFF, 4'd2);
    check("b2b_c1_in_ready", in_ready, 0);
    check("b2b_c1_opcode", alu_opcode, 10);
    tick();
    check("b2b_c2_opcode_held", alu_opcode, 10);
    tick();                                   // XOR result
    t_first = cyc;
    check("b2b_xor_valid", res_valid, 1);
    check("b2b_xor_data", res_data, 32'hF0F0_0F0F);
    check("b2b_xor_tag", res_tag, 1);
    check("b2b_accept_same_edge", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("b2b_nor_enable", alu_enable, 1);
    check("b2b_nor_opcode", alu_opcode, 12);
    check("b2b_gap_valid", res_valid, 0);
    tick();
    tick();                                   // NOR result
    check("b2b_nor_valid", res_valid, 1);
    check("b2b_spacing", cyc - t_first, 3);
    check("b2b_nor_data", res_data, 32'hEDCB_0000);
    check("b2b_nor_tag", res_tag, 2);
    tick();
    check("b2b_idle", busy, 0);

    // ---------------- illegal opcode ----------------
    drive_req(5'd20, 32'h5555_5555, 32'h5555_5555, 4'd7);
    check("ill_c0_enable", alu_enable, 0);
    tick();
    in_valid = 1'b0;
    check("ill_c1_enable", alu_enable, 0);
    check("ill_c1_valid", res_valid, 1);
    check("ill_c1_data", res_data, 0);
    check("ill_c1_err", res_err, 1);
    check("ill_c1_tag", res_tag, 7);
    tick();
    check("ill_retired", res_valid, 0);

    // ---------------- reset mid-EXEC ----------------
    drive_req(5'd8, 32'hFFFF_FFFF, 32'h1234_5678, 4'd5);
    tick();                                   // cycle 1, EXEC
    in_valid = 1'b0;
    check("rme_c1_enable", alu_enable, 1);
    rst = 1'b1;
    #0;
    check("rme_in_ready_in_rst", in_ready, 0);
    tick();
    rst = 1'b0;
    #0;
    check("rme_busy", busy, 0);
    check("rme_enable", alu_enable, 0);
    check("rme_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      check("rme_no_result", res_valid, 0);
      tick();
    end

    // Follow-up request must still complete with normal latency.
    drive_req(5'd8, 32'h0FF0_0FF0, 32'h00FF_FF00, 4'd6);
    t_first = cyc;
    tick();
    in_valid = 1'b0;
    waited = 0;
    while (!res_valid && waited < 10) begin
      tick();
      waited++;
    end
    check("rme_follow_valid", res_valid, 1);
    check("rme_follow_latency", cyc - t_first, LAT + 1);
    check("rme_follow_data", res_data, 32'h00F0_0F00);
    check("rme_follow_tag", res_tag, 6);
    check("rme_follow_err", res_err, 0);
    tick();
    check("rme_follow_retired", res_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequencer that sits directly upstream of the `alu` block and also consumes its result. It accepts one operation at a time over a valid/ready handshake and drives `opcode`, `a`, `b` and `enable` into the ALU. It holds those signals stable for a fixed number of cycles, captures `out`, and presents the result downstream with a valid/ready handshake. It isolates the rest of the processor from the ALU's non-pipelined, enable-gated timing.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width.
- `OPW`, default 5: opcode width.
- `TAGW`, default 4: width of the tag passed through from request to result.
- `LAT`, default 2: number of cycles `alu_enable` is held before `alu_out` is sampled. Must be at least 1.

Ports:
- `clk`, in, 1: the only clock. All state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: request valid.
- `in_ready`, out, 1: request accepted on an edge where `in_valid` and `in_ready` are both 1.
- `in_opcode`, in, OPW: ALU opcode.
- `in_a`, in, WIDTH: operand A.
- `in_b`, in, WIDTH: operand B.
- `in_tag`, in, TAGW: request tag.
- `alu_opcode`, out, OPW: drives ALU `opcode`.
- `alu_a`, out, WIDTH: drives ALU `a`.
- `alu_b`, out, WIDTH: drives ALU `b`.
- `alu_enable`, out, 1: drives ALU `enable`.
- `alu_out`, in, WIDTH: ALU `out`.
- `res_valid`, out, 1: result valid.
- `res_ready`, in, 1: downstream accepts the result.
- `res_data`, out, WIDTH: result value.
- `res_tag`, out, TAGW: tag of the request that produced this result.
- `res_err`, out, 1: 1 means the opcode was illegal and `res_data` is 0.
- `busy`, out, 1: 1 in any state other than IDLE.

## Operation
States: IDLE, EXEC, RESP.
- **IDLE:**
  - `in_ready` = 1.
  - On acceptance, latch opcode, a, b and tag into operand registers.
  - If opcode < 16, go to EXEC and load the counter with LAT-1.
  - If opcode >= 16 (illegal), go straight to RESP with `res_data` = 0 and `res_err` = 1. The ALU is not enabled.
- **EXEC:**
  - `alu_enable` = 1 and `in_ready` = 0.
  - `alu_opcode`, `alu_a` and `alu_b` come from the operand registers and are stable for every EXEC cycle.
  - The counter decrements each cycle.
  - On the edge where the counter is 0, capture `alu_out` into `res_data`, set `res_err` = 0, and go to RESP.
- **RESP:**
  - `res_valid` = 1.
  - `res_data`, `res_tag` and `res_err` are held stable while `res_ready` = 0.
  - `in_ready` = `res_ready`, computed combinationally from state and `res_ready` only.
  - On an edge with `res_ready` = 1:
    - If `in_valid` = 1, retire the result and accept the new request on that same edge. Next state follows the IDLE acceptance rules.
    - Otherwise go to IDLE.
- **Outside EXEC:**
  - `alu_enable` = 0.
  - `alu_opcode`, `alu_a` and `alu_b` keep the last latched operand values. This avoids toggling the ALU inputs.
- **Data path:**
  - `res_data` is a straight WIDTH-bit copy of `alu_out`. No arithmetic is done in this block.
  - The counter is $clog2(LAT) bits wide, with a minimum of 1 bit.

## Timing
- **Reset:**
  - While `rst` = 1: next state is IDLE and `in_ready` = 0 combinationally.
  - On the reset edge, all registers go to 0. `alu_opcode`/`alu_a`/`alu_b`/`alu_enable`, `res_valid`/`res_data`/`res_tag`/`res_err` and `busy` are all 0.
  - First cycle after reset is released: `in_ready` = 1.
- **Legal-op latency:**
  - Request accepted at the end of cycle 0.
  - `alu_enable` = 1 for cycles 1 through LAT.
  - `alu_out` is sampled at the end of cycle LAT.
  - `res_valid` = 1 from cycle LAT+1.
- **Illegal-op latency:** `res_valid` = 1 in cycle 1.
- **Throughput:** with `res_ready` tied to 1 and back-to-back requests, one legal op every LAT+1 cycles.
- **Reset mid-operation:** `rst` during EXEC or RESP abandons the operation. No result is presented and `res_valid` drops on the next cycle.
- **Unaccepted requests:** `in_valid` while `in_ready` = 0 is ignored. No request is lost, because the requester must hold `in_valid`.
- **Backpressure:** `res_ready` = 0 in RESP stalls indefinitely with all outputs frozen.

## Test plan
The bench uses a behavioural ALU model that produces a valid `out` after LAT enabled cycles, with LAT = 2.
- **Reset values:** assert `rst` for 2 cycles -> every output is 0. `in_ready` = 1 in the first cycle after release.
- **AND:** opcode 8, a = 0xF0F0F0F0, b = 0xFF00FF00, tag 3 ->
  - `alu_enable` is high exactly for cycles 1 and 2.
  - `res_valid` in cycle 3 with `res_data` = 0xF000F000, `res_tag` = 3, `res_err` = 0.
- **Backpressure:** OR op (opcode 9, a = 0x0000000F, b = 0x000000F0) with `res_ready` held at 0 for 5 cycles ->
  - `res_data` = 0x000000FF stable, `in_ready` = 0 and `alu_enable` = 0 throughout.
  - Retires on the first edge with `res_ready` = 1.
- **Back-to-back:** XOR (opcode 10) then NOR (opcode 12), second `in_valid` held, `res_ready` = 1 ->
  - The second request is accepted on the same edge the first result retires.
  - Results are spaced 3 cycles apart, with correct tags.
- **Illegal opcode:** opcode 20, tag 7 ->
  - `alu_enable` never asserts.
  - `res_valid` in cycle 1 with `res_data` = 0, `res_err` = 1, `res_tag` = 7.
- **Reset mid-EXEC:** assert `rst` in cycle 1 of an AND op ->
  - No `res_valid` ever appears for that op.
  - State returns to IDLE and a following request completes normally.
